jts16_palrd: RTL

Palette reader at the consumer end of the priority mixer's `{shadow, pal_addr}` output. Holds the 2048×16 palette RAM, which is written and read by the 68000 through a chip-select/ok handshake. On each pixel it looks up the colour word for the mixer's address and applies shadow or highlight. It drives pipelined, blank-gated 5-bit RGB to the video output stage.

---
 rtl/jts16_pal_pkg.sv | 41 ++++
 rtl/jts16_pal_ram.sv | 49 ++++
 rtl/jts16_palrd.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/jts16_pal_pkg.sv
// Shared constants, palette word layout, CPU FSM states and colour helpers for
// the jts16 palette reader.
package jts16_pal_pkg;

    localparam int unsigned PAL_PW     = 11;
    localparam int unsigned HILITE_BIT = 15;
    localparam int unsigned B0_BIT     = 14;
    localparam int unsigned G0_BIT     = 13;
    localparam int unsigned R0_BIT     = 12;
    localparam int unsigned B_LSB      = 8;
    localparam int unsigned G_LSB      = 4;
    localparam int unsigned R_LSB      = 0;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} cpu_st_e;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb_t;

    // The 4-bit field holds the upper channel bits; the LSB sits in [14:12].
    function automatic rgb_t unpack_rgb(input logic [15:0] w);
        rgb_t c;
        c.r = {w[R_LSB+:4], w[R0_BIT]};
        c.g = {w[G_LSB+:4], w[G0_BIT]};
        c.b = {w[B_LSB+:4], w[B0_BIT]};
        return c;
    endfunction

    function automatic logic [4:0] shade(input logic [4:0] c, input logic sh, input logic hi);
        if (sh) begin
            return c >> 1;
        end else if (hi) begin
            return c + ((5'd31 - c) >> 1);
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/jts16_pal_ram.sv
// True dual-port palette RAM: port A for the CPU with byte write-enables,
// port B read-only for video, clock-enabled by the pixel enable. Read-first.
module jts16_pal_ram #(
    parameter int unsigned PW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] i_a_addr,
    input  logic [15:0]   i_a_din,
    input  logic [1:0]    i_a_we,
    input  logic          i_a_re,
    output logic [15:0]   o_a_dout,
    input  logic          i_b_cen,
    input  logic [PW-1:0] i_b_addr,
    output logic [15:0]   o_b_dout
);

    localparam int unsigned DEPTH = 2 ** PW;

    logic [15:0] r_mem [0:DEPTH-1];
    logic [15:0] r_a_dout;
    logic [15:0] r_b_dout;

    always_ff @(posedge clk) begin
        if (i_a_we[1]) r_mem[i_a_addr][15:8] <= i_a_din[15:8];
        if (i_a_we[0]) r_mem[i_a_addr][7:0]  <= i_a_din[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_dout <= '0;
        end else if (i_a_re) begin
            r_a_dout <= r_mem[i_a_addr];
        end
    end

    // Same-edge write lands after this read, so video sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_dout <= '0;
        end else if (i_b_cen) begin
            r_b_dout <= r_mem[i_b_addr];
        end
    end

    assign o_a_dout = r_a_dout;
    assign o_b_dout = r_b_dout;

endmodule

// File: rtl/jts16_palrd.sv
// Palette reader: CPU-accessible palette RAM plus a 2-tick pixel pipeline with
// shadow/highlight and blanking. Optional JTS16_PAL_BYPASS_EN adds a grey-ramp debug mode.
module jts16_palrd
    import jts16_pal_pkg::*;
#(
    parameter int unsigned PW          = PAL_PW,
    parameter bit          BLANK_BLACK = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic [PW-1:0] pal_addr,
    input  logic          shadow,
    input  logic          LHBL,
    input  logic          LVBL,
`ifdef JTS16_PAL_BYPASS_EN
    input  logic          pal_bypass,
`endif
    input  logic [PW-1:0] cpu_addr,
    input  logic [15:0]   cpu_dout,
    input  logic [1:0]    cpu_dsn,
    input  logic          cpu_rnw,
    input  logic          pal_cs,
    output logic [15:0]   pal_dout,
    output logic          pal_ok,
    output logic [4:0]    red,
    output logic [4:0]    green,
    output logic [4:0]    blue,
    output logic          LHBL_dly,
    output logic          LVBL_dly
);

    cpu_st_e       r_st;
    cpu_st_e       w_st_nxt;
    logic          r_cs_prev;
    logic [PW-1:0] r_addr;
    logic          r_ok;
    logic          w_ok_nxt;
    logic          w_cs_rise;
    logic [1:0]    w_we;
    logic          w_re;
    logic [PW-1:0] w_ram_addr;
    logic [15:0]   w_a_dout;
    logic [15:0]   w_b_dout;

    assign w_cs_rise = pal_cs & ~r_cs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            IDLE:    if (w_cs_rise) w_st_nxt = ACCESS;
            ACCESS:  w_st_nxt = pal_cs ? DONE : IDLE;
            DONE:    if (!pal_cs) w_st_nxt = IDLE;
            default: w_st_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_we       = 2'b00;
        w_re       = 1'b0;
        w_ok_nxt   = 1'b0;
        w_ram_addr = cpu_addr;
        case (r_st)
            IDLE: begin
                if (w_cs_rise && !cpu_rnw) w_we = ~cpu_dsn;
            end
            ACCESS: begin
                w_ram_addr = r_addr;
                w_re       = pal_cs;
                w_ok_nxt   = pal_cs;
            end
            DONE: begin
                w_ok_nxt = pal_cs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_prev <= 1'b0;
            r_addr    <= '0;
            r_ok      <= 1'b0;
        end else begin
            r_cs_prev <= pal_cs;
            r_ok      <= w_ok_nxt;
            if (r_st == IDLE && w_cs_rise) r_addr <= cpu_addr;
        end
    end

    jts16_pal_ram #(
        .PW (PW)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_a_addr (w_ram_addr),
        .i_a_din  (cpu_dout),
        .i_a_we   (w_we),
        .i_a_re   (w_re),
        .o_a_dout (w_a_dout),
        .i_b_cen  (pxl_cen),
        .i_b_addr (pal_addr),
        .o_b_dout (w_b_dout)
    );

    assign pal_dout = w_a_dout;
    assign pal_ok   = r_ok;

    // Stage 1 side-band, aligned with the RAM read of port B
    logic r_sh_s;
    logic r_lhbl_s;
    logic r_lvbl_s;
`ifdef JTS16_PAL_BYPASS_EN
    logic [4:0] r_pix_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_s   <= 1'b0;
            r_lhbl_s <= 1'b0;
            r_lvbl_s <= 1'b0;
`ifdef JTS16_PAL_BYPASS_EN
            r_pix_s  <= '0;
`endif
        end else if (pxl_cen) begin
            r_sh_s   <= shadow;
            r_lhbl_s <= LHBL;
            r_lvbl_s <= LVBL;
`ifdef JTS16_PAL_BYPASS_EN
            r_pix_s  <= pal_addr[4:0];
`endif
        end
    end

    rgb_t w_raw;
    rgb_t w_out;
    logic w_blank;

    always_comb begin
        w_raw   = unpack_rgb(w_b_dout);
        w_out.r = shade(w_raw.r, r_sh_s, w_b_dout[HILITE_BIT]);
        w_out.g = shade(w_raw.g, r_sh_s, w_b_dout[HILITE_BIT]);
        w_out.b = shade(w_raw.b, r_sh_s, w_b_dout[HILITE_BIT]);
`ifdef JTS16_PAL_BYPASS_EN
        if (pal_bypass) begin
            w_out.r = r_pix_s;
            w_out.g = r_pix_s;
            w_out.b = r_pix_s;
        end
`endif
        w_blank = BLANK_BLACK && (!r_lhbl_s || !r_lvbl_s);
        if (w_blank) w_out = '0;
    end

    logic [4:0] r_red;
    logic [4:0] r_green;
    logic [4:0] r_blue;
    logic       r_lhbl_dly;
    logic       r_lvbl_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
            r_lhbl_dly <= 1'b0;
            r_lvbl_dly <= 1'b0;
        end else if (pxl_cen) begin
            r_red      <= w_out.r;
            r_green    <= w_out.g;
            r_blue     <= w_out.b;
            r_lhbl_dly <= r_lhbl_s;
            r_lvbl_dly <= r_lvbl_s;
        end
    end

    assign red      = r_red;
    assign green    = r_green;
    assign blue     = r_blue;
    assign LHBL_dly = r_lhbl_dly;
    assign LVBL_dly = r_lvbl_dly;

endmodule
